// File: rtl/cdc_fifo_wr_ctrl.sv
// cdc_fifo_wr_ctrl: write-side controller of an asynchronous (CDC) FIFO.
// Keeps the binary and Gray write pointers and drives the RAM write strobe and
// address. Synchronises the read-domain Gray pointer and produces full. Runs a
// flush/drain handshake: writes stop until the reader catches up.
//
// Optional feature macro: CDC_WR_CTRL_LEVEL_EN. When it is defined, the
// controller adds a registered fill level and an almost-full flag.
//
// Ports:
//   clk         write-domain clock
//   sysRst      synchronous active-high reset
//   wrValid     requester has a word to write
//   wrReady     controller can accept a word (combinational)
//   wrEn        RAM write strobe, wrValid & wrReady (combinational)
//   wrAddr      RAM write address, low bits of the binary write pointer
//   wrPtrGray   registered Gray write pointer, sent to the read domain
//   rdPtrGray   Gray read pointer from the read domain (asynchronous)
//   flushReq    level request: stop writing and wait for the FIFO to drain
//   flushDone   registered; the FIFO has drained while flushing
//   full        FIFO full, judged against the synchronised read pointer
//   level       fill level, registered (CDC_WR_CTRL_LEVEL_EN only)
//   almostFull  level >= ALMOST_FULL_THRESH (CDC_WR_CTRL_LEVEL_EN only)
module cdc_fifo_wr_ctrl #(
    parameter int unsigned ADDR_WIDTH         = 4,
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned ALMOST_FULL_THRESH = 12
) (
    input  logic                  clk,
    input  logic                  sysRst,
    input  logic                  wrValid,
    output logic                  wrReady,
    output logic                  wrEn,
    output logic [ADDR_WIDTH-1:0] wrAddr,
    output logic [ADDR_WIDTH:0]   wrPtrGray,
    input  logic [ADDR_WIDTH:0]   rdPtrGray,
    input  logic                  flushReq,
    output logic                  flushDone,
    output logic                  full
`ifdef CDC_WR_CTRL_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almostFull
`endif
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_FLUSH_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH_DONE = 2'd2;

    // Elaboration guard on the parameter ranges
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || ADDR_WIDTH < 2 ||
        ALMOST_FULL_THRESH > (2 ** ADDR_WIDTH)) begin : g_param_err
        $error("cdc_fifo_wr_ctrl: illegal parameter combination");
    end

    logic [1:0]    state_q,     state_d;
    logic [PW-1:0] wr_bin_q,    wr_bin_d;
    logic [PW-1:0] wr_gray_q,   wr_gray_d;
    logic          flush_done_q, flush_done_d;
    logic [PW-1:0] rd_sync_q [SYNC_STAGES];
    logic [PW-1:0] rd_sync_d [SYNC_STAGES];
    logic [PW-1:0] rd_last;
    logic [PW-1:0] wr_bin_inc;
    logic          full_c;
    logic          ready_c;
    logic          wr_en_c;
    logic          drained_c;

    assign rd_last = rd_sync_q[SYNC_STAGES-1];

    // Full when the pointers differ only in their top two Gray bits
    assign full_c    = (wr_gray_q == {~rd_last[PW-1:PW-2], rd_last[PW-3:0]});
    assign drained_c = (wr_gray_q == rd_last);
    // Reset gating keeps the RAM untouched while sysRst is held
    assign ready_c   = (state_q == ST_RUN) && !full_c && !sysRst;
    assign wr_en_c   = wrValid && ready_c;

    assign wrReady   = ready_c;
    assign wrEn      = wr_en_c;
    assign full      = full_c;
    assign wrAddr    = wr_bin_q[ADDR_WIDTH-1:0];
    assign wrPtrGray = wr_gray_q;
    assign flushDone = flush_done_q;

    // Read-pointer synchroniser chain
    always_comb begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
            rd_sync_d[i] = '0;
        end
        rd_sync_d[0] = rdPtrGray;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            rd_sync_d[i] = rd_sync_q[i-1];
        end
    end

    // Write pointer advance; both encodings update on the same edge
    always_comb begin
        wr_bin_inc = wr_bin_q + PW'(1);
        wr_bin_d   = wr_bin_q;
        wr_gray_d  = wr_gray_q;
        if (wr_en_c) begin
            wr_bin_d  = wr_bin_inc;
            wr_gray_d = wr_bin_inc ^ (wr_bin_inc >> 1);
        end
    end

    // Flush handshake; pointers are left alone so the reader stays consistent
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flushReq) begin
                    state_d = ST_FLUSH_WAIT;
                end
            end
            ST_FLUSH_WAIT: begin
                if (!flushReq) begin
                    state_d = ST_RUN;
                end else if (drained_c) begin
                    state_d = ST_FLUSH_DONE;
                end
            end
            ST_FLUSH_DONE: begin
                if (!flushReq) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        flush_done_d = (state_d == ST_FLUSH_DONE);
    end

    always_ff @(posedge clk) begin
        if (sysRst) begin
            state_q      <= ST_RUN;
            wr_bin_q     <= '0;
            wr_gray_q    <= '0;
            flush_done_q <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rd_sync_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_bin_q     <= wr_bin_d;
            wr_gray_q    <= wr_gray_d;
            flush_done_q <= flush_done_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rd_sync_q[i] <= rd_sync_d[i];
            end
        end
    end

`ifdef CDC_WR_CTRL_LEVEL_EN
    logic [PW-1:0] rd_bin_sync;
    logic [PW-1:0] level_q, level_d;

    // Gray -> binary of the synchronised read pointer
    always_comb begin
        rd_bin_sync         = '0;
        rd_bin_sync[PW-1]   = rd_last[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            rd_bin_sync[i] = rd_bin_sync[i+1] ^ rd_last[i];
        end
        level_d = wr_bin_q - rd_bin_sync;
    end

    always_ff @(posedge clk) begin
        if (sysRst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level      = level_q;
    assign almostFull = (level_q >= PW'(ALMOST_FULL_THRESH));
`endif

endmodule

// File: tb/tb_cdc_fifo_wr_ctrl.sv
// Directed bench for cdc_fifo_wr_ctrl (ADDR_WIDTH=4, SYNC_STAGES=2, thresh 12).
// Inputs change 1 time unit after the rising edge; outputs are sampled after that.
module tb_cdc_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       sysRst;
    logic       wrValid;
    logic       wrReady;
    logic       wrEn;
    logic [3:0] wrAddr;
    logic [4:0] wrPtrGray;
    logic [4:0] rdPtrGray;
    logic       flushReq;
    logic       flushDone;
    logic       full;
`ifdef CDC_WR_CTRL_LEVEL_EN
    logic [4:0] level;
    logic       almostFull;
`endif

    int total = 0;
    int bad   = 0;

    cdc_fifo_wr_ctrl #(
        .ADDR_WIDTH         (4),
        .SYNC_STAGES        (2),
        .ALMOST_FULL_THRESH (12)
    ) dut (
        .clk        (clk),
        .sysRst     (sysRst),
        .wrValid    (wrValid),
        .wrReady    (wrReady),
        .wrEn       (wrEn),
        .wrAddr     (wrAddr),
        .wrPtrGray  (wrPtrGray),
        .rdPtrGray  (rdPtrGray),
        .flushReq   (flushReq),
        .flushDone  (flushDone),
        .full       (full)
`ifdef CDC_WR_CTRL_LEVEL_EN
        ,
        .level      (level),
        .almostFull (almostFull)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] to_gray(input int unsigned b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ {1'b0, v[4:1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        sysRst    = 1'b1;
        wrValid   = 1'b0;
        flushReq  = 1'b0;
        rdPtrGray = 5'd0;
        tick();
        tick();
        sysRst = 1'b0;
        #1;
    endtask

    // Test 1: fill from empty, 16 writes then full
    task automatic test_fill();
        int n;
        apply_reset();
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (wrReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", wrReady); end
        total++; if (wrPtrGray !== 5'd0) begin bad++; $display("FAIL reset_gray got=%b exp=00000", wrPtrGray); end
        total++; if (flushDone !== 1'b0) begin bad++; $display("FAIL reset_flushdone got=%b exp=0", flushDone); end
        n = 0;
        wrValid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (wrEn === 1'b1) begin
                total++;
                if (wrAddr !== 4'(n)) begin bad++; $display("FAIL fill_addr got=%0d exp=%0d", wrAddr, n); end
                n++;
            end
            tick();
        end
        total++; if (n != 16) begin bad++; $display("FAIL fill_count got=%0d exp=16", n); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
        total++; if (wrReady !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", wrReady); end
        total++; if (wrPtrGray !== 5'b11000) begin bad++; $display("FAIL fill_gray got=%b exp=11000", wrPtrGray); end
    endtask

    // Test 2: one read frees one slot after the synchroniser delay
    task automatic test_full_release();
        rdPtrGray = 5'b00001;
        tick();
        total++; if (full !== 1'b1) begin bad++; $display("FAIL rel_full_1edge got=%b exp=1", full); end
        tick();
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rel_full_2edge got=%b exp=0", full); end
        total++; if (wrEn !== 1'b1) begin bad++; $display("FAIL rel_wren got=%b exp=1", wrEn); end
        total++; if (wrAddr !== 4'd0) begin bad++; $display("FAIL rel_addr got=%0d exp=0", wrAddr); end
        tick();
        total++; if (full !== 1'b1) begin bad++; $display("FAIL rel_refull got=%b exp=1", full); end
        total++; if (wrPtrGray !== 5'b11001) begin bad++; $display("FAIL rel_gray got=%b exp=11001", wrPtrGray); end
        wrValid = 1'b0;
    endtask

    // Test 3: reader follows the writer, 40 writes with wrap
    task automatic test_stream();
        int  n;
        bit  saw_full;
        apply_reset();
        n = 0;
        saw_full = 1'b0;
        wrValid = 1'b1;
        for (int c = 0; c < 100 && n < 40; c++) begin
            rdPtrGray = to_gray(n);
            #1;
            if (full === 1'b1) saw_full = 1'b1;
            if (wrEn === 1'b1) begin
                total++;
                if (wrAddr !== 4'(n)) begin bad++; $display("FAIL stream_addr got=%0d exp=%0d", wrAddr, n % 16); end
                n++;
            end
            tick();
        end
        wrValid = 1'b0;
        total++; if (n != 40) begin bad++; $display("FAIL stream_count got=%0d exp=40", n); end
        total++; if (saw_full) begin bad++; $display("FAIL stream_full got=1 exp=0"); end
        total++; if (wrPtrGray !== 5'b01100) begin bad++; $display("FAIL stream_gray got=%b exp=01100", wrPtrGray); end
        total++; if (wrAddr !== 4'd8) begin bad++; $display("FAIL stream_wrapaddr got=%0d exp=8", wrAddr); end
    endtask

    // Test 4: flush, drain, release
    task automatic test_flush();
        apply_reset();
        wrValid = 1'b1;
        tick(); tick(); tick();
        wrValid  = 1'b0;
        flushReq = 1'b1;
        #1;
        total++; if (wrReady !== 1'b1) begin bad++; $display("FAIL flush_req_cycle_ready got=%b exp=1", wrReady); end
        tick();
        wrValid = 1'b1;
        #1;
        total++; if (wrReady !== 1'b0) begin bad++; $display("FAIL flush_wait_ready got=%b exp=0", wrReady); end
        total++; if (wrEn !== 1'b0) begin bad++; $display("FAIL flush_wait_wren got=%b exp=0", wrEn); end
        total++; if (flushDone !== 1'b0) begin bad++; $display("FAIL flush_wait_done got=%b exp=0", flushDone); end
        rdPtrGray = 5'b00010;
        tick(); tick();
        total++; if (flushDone !== 1'b0) begin bad++; $display("FAIL flush_done_early got=%b exp=0", flushDone); end
        tick();
        total++; if (flushDone !== 1'b1) begin bad++; $display("FAIL flush_done got=%b exp=1", flushDone); end
        total++; if (wrPtrGray !== 5'b00010) begin bad++; $display("FAIL flush_gray got=%b exp=00010", wrPtrGray); end
        total++; if (wrReady !== 1'b0) begin bad++; $display("FAIL flush_done_ready got=%b exp=0", wrReady); end
        wrValid  = 1'b0;
        flushReq = 1'b0;
        tick();
        total++; if (flushDone !== 1'b0) begin bad++; $display("FAIL flush_exit_done got=%b exp=0", flushDone); end
        total++; if (wrReady !== 1'b1) begin bad++; $display("FAIL flush_exit_ready got=%b exp=1", wrReady); end
    endtask

    // Test 5: reset wins over a pending flush and a live write request
    task automatic test_reset_in_flush();
        apply_reset();
        wrValid = 1'b1;
        tick(); tick();
        flushReq = 1'b1;
        tick();
        #1;
        total++; if (wrReady !== 1'b0) begin bad++; $display("FAIL rstfl_wait_ready got=%b exp=0", wrReady); end
        total++; if (wrPtrGray !== 5'b00010) begin bad++; $display("FAIL rstfl_gray got=%b exp=00010", wrPtrGray); end
        sysRst = 1'b1;
        #1;
        total++; if (wrEn !== 1'b0) begin bad++; $display("FAIL rstfl_wren got=%b exp=0", wrEn); end
        tick();
        sysRst  = 1'b0;
        wrValid = 1'b0;
        #1;
        total++; if (wrReady !== 1'b1) begin bad++; $display("FAIL rstfl_run_ready got=%b exp=1", wrReady); end
        total++; if (wrPtrGray !== 5'd0) begin bad++; $display("FAIL rstfl_gray0 got=%b exp=00000", wrPtrGray); end
        total++; if (flushDone !== 1'b0) begin bad++; $display("FAIL rstfl_done got=%b exp=0", flushDone); end
        flushReq = 1'b0;
        tick();
    endtask

    // Test 6: flush requested while full blocks the write
    task automatic test_full_flush();
        apply_reset();
        wrValid = 1'b1;
        for (int c = 0; c < 16; c++) tick();
        flushReq = 1'b1;
        #1;
        total++; if (wrEn !== 1'b0) begin bad++; $display("FAIL fullfl_wren got=%b exp=0", wrEn); end
        tick();
        total++; if (wrPtrGray !== 5'b11000) begin bad++; $display("FAIL fullfl_gray got=%b exp=11000", wrPtrGray); end
        total++; if (flushDone !== 1'b0) begin bad++; $display("FAIL fullfl_done got=%b exp=0", flushDone); end
        wrValid  = 1'b0;
        flushReq = 1'b0;
        tick();
    endtask

`ifdef CDC_WR_CTRL_LEVEL_EN
    // Test 7: registered fill level and almost-full threshold
    task automatic test_level();
        apply_reset();
        total++; if (level !== 5'd0) begin bad++; $display("FAIL lvl_reset got=%0d exp=0", level); end
        wrValid = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        wrValid   = 1'b0;
        rdPtrGray = 5'b00011;
        tick(); tick(); tick();
        total++; if (level !== 5'd3) begin bad++; $display("FAIL lvl_3 got=%0d exp=3", level); end
        total++; if (almostFull !== 1'b0) begin bad++; $display("FAIL lvl_af3 got=%b exp=0", almostFull); end
        wrValid = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        wrValid = 1'b0;
        tick();
        total++; if (level !== 5'd11) begin bad++; $display("FAIL lvl_11 got=%0d exp=11", level); end
        total++; if (almostFull !== 1'b0) begin bad++; $display("FAIL lvl_af11 got=%b exp=0", almostFull); end
        wrValid = 1'b1;
        tick();
        wrValid = 1'b0;
        tick();
        total++; if (level !== 5'd12) begin bad++; $display("FAIL lvl_12 got=%0d exp=12", level); end
        total++; if (almostFull !== 1'b1) begin bad++; $display("FAIL lvl_af12 got=%b exp=1", almostFull); end
    endtask
`endif

    initial begin
        sysRst    = 1'b1;
        wrValid   = 1'b0;
        flushReq  = 1'b0;
        rdPtrGray = 5'd0;
        test_fill();
        test_full_release();
        test_stream();
        test_flush();
        test_reset_in_flush();
        test_full_flush();
`ifdef CDC_WR_CTRL_LEVEL_EN
        test_level();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
